// File: rtl/pipeline_skid_stage.sv
// Elastic pipeline register: valid/ready handshake, two-entry skid buffer, registered in_ready, sync flush.
// Define PIPE_STAGE_STATS_EN to build the saturating stall counter on stall_count.

module skidField #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             loadMainIn,
  input  logic             loadMainSkid,
  input  logic             loadSkid,
  input  logic [WIDTH-1:0] inWord,
  output logic [WIDTH-1:0] mainWord
);
  logic [WIDTH-1:0] skidWord;

  // Cleared words read as NOP downstream.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mainWord <= '0;
      skidWord <= '0;
    end else if (clear) begin
      mainWord <= '0;
      skidWord <= '0;
    end else begin
      if (loadMainIn)        mainWord <= inWord;
      else if (loadMainSkid) mainWord <= skidWord;
      if (loadSkid)          skidWord <= inWord;
    end
  end
endmodule

module pipeline_skid_stage #(
  parameter int WIDTH  = 32,
  parameter int FIELDS = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*FIELDS-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH*FIELDS-1:0] out_data,
  output logic [CNT_W-1:0]        stall_count
);
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t stateQ, stateD;
  logic   inReadyQ;
  logic   accept, transfer;
  logic   loadMainIn, loadMainSkid, loadSkid;

  logic [FIELDS-1:0][WIDTH-1:0] inFields, mainFields;

  assign accept    = in_valid & inReadyQ;
  assign transfer  = out_valid & out_ready;
  assign out_valid = (stateQ != EMPTY);
  assign in_ready  = inReadyQ;
  assign inFields  = in_data;
  assign out_data  = mainFields;

  always_comb begin
    stateD       = stateQ;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    case (stateQ)
      EMPTY: if (accept) begin
        loadMainIn = 1'b1;
        stateD     = FULL;
      end
      FULL: begin
        if (accept && transfer) loadMainIn = 1'b1;
        else if (transfer)      stateD = EMPTY;
        else if (accept) begin
          loadSkid = 1'b1;
          stateD   = SKID;
        end
      end
      SKID: if (transfer) begin
        loadMainSkid = 1'b1;
        stateD       = FULL;
      end
      default: stateD = EMPTY;
    endcase
    // Flush squashes everything, including a word offered this cycle.
    if (flush) begin
      stateD       = EMPTY;
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
    end
  end

  // in_ready is precomputed from the next state so no ready path crosses stages.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ   <= EMPTY;
      inReadyQ <= 1'b1;
    end else begin
      stateQ   <= stateD;
      inReadyQ <= (stateD != SKID);
    end
  end

  for (genvar k = 0; k < FIELDS; k++) begin : gField
    skidField #(.WIDTH(WIDTH)) uField (
      .clock       (clock),
      .reset       (reset),
      .clear       (flush),
      .loadMainIn  (loadMainIn),
      .loadMainSkid(loadMainSkid),
      .loadSkid    (loadSkid),
      .inWord      (inFields[k]),
      .mainWord    (mainFields[k])
    );
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stallQ;

  // Survives flush; only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                    stallQ <= '0;
    else if (out_valid && !out_ready && stallQ != '1) stallQ <= stallQ + CNT_W'(1);
  end
  assign stall_count = stallQ;
`else
  assign stall_count = '0;
`endif
endmodule
